sample_packetizer: RTL and testbench
====================================

# sample_packetizer

Buffers 16-bit ADC samples coming out of the deserializer and frames them for the 2-byte UART transmitter. It sits between the SIPO output (`deser_out` qualified by `adc_ready`) and `uart_tx`, and replaces the direct `adc_ready -> tx_start` connection. A FIFO absorbs bursts. A framing FSM emits, for each frame:

- one header word,
- FRAME_LEN sample words,
- one 16-bit checksum word.

Each word is sent with the tx_start/tx_busy handshake.

## Interface

Parameters:
- DEPTH, 16, FIFO depth in samples; power of 2, ≥ 2.
- FRAME_LEN, 8, samples per frame; 1 ≤ FRAME_LEN ≤ DEPTH.
- HEADER, 16'hA55A, sync word sent first in every frame.

Ports:
- clk  in  1  system clock (100 MHz PLL output).
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; sample_data is valid this cycle.
- sample_data  in  16  ADC sample.
- tx_busy  in  1  UART busy flag.
- tx_start  out  1  one-cycle start strobe to the UART.
- tx_data  out  16  word to transmit; held stable from tx_start until the word completes.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set on the first dropped sample.
- drop_count  out  8  dropped samples; saturates at 255.
- frame_active  out  1  high from header start until checksum completion.

## Operation

FIFO:
- Circular buffer with read/write pointers of width $clog2(DEPTH), wrapping naturally.
- Separate occupancy counter.
- Push is accepted iff sample_valid=1 and fifo_count < DEPTH, evaluated on the current-cycle count. A pop in the same cycle does not free space for that push.
- A rejected push sets overflow and increments drop_count (saturating at 255). The FIFO is unchanged.
- Simultaneous push and pop leaves fifo_count unchanged.
- No bypass: a pushed sample is poppable from the next cycle on.

FSM states:
- IDLE
  - If fifo_count ≥ FRAME_LEN and tx_busy=0: load tx_data=HEADER, clear checksum and sample index, go to SEND.
  - Set frame_active=1 on this transition.
- SEND
  - tx_start=1 for exactly this one cycle. Go to ACK.
- ACK
  - Wait for tx_busy=1, then go to DONE.
- DONE
  - Wait for tx_busy=0, then select the next word:
  - After the header, or after a sample with index < FRAME_LEN-1: pop the FIFO head into tx_data, add it to checksum (mod 2^16), increment index, go to SEND.
  - After the last sample: tx_data=checksum, go to SEND.
  - After the checksum: frame_active=0, go to IDLE.

Checksum:
- 16-bit unsigned sum of the frame's FRAME_LEN samples; carry discarded.
- The header is not included.

The FRAME_LEN samples in a frame are always consecutive FIFO entries. A frame never starts with fewer than FRAME_LEN samples buffered, so a pop never finds the FIFO empty.

## Timing

Reset values:
- tx_start=0, tx_data=0, fifo_count=0, overflow=0, drop_count=0, frame_active=0.
- FSM=IDLE, pointers=0, checksum=0.

Reset behaviour:
- Reset mid-frame aborts the frame and flushes the FIFO.
- tx_start is low in the cycle after rst is sampled.
- A UART byte already in flight is not cancelled.

Latencies:
- Push at cycle t: fifo_count updates at t+1.
- If that push makes fifo_count=FRAME_LEN and tx_busy=0: tx_start for the header fires at t+2.
- DONE → next SEND: 1 cycle after tx_busy is sampled low.
- tx_data changes only on entry to SEND; it is constant through ACK and DONE.

tx_start rules:
- Never high in two consecutive cycles.
- Never high while in ACK or DONE.

Throughput: one word per UART completion plus 2 cycles of FSM overhead.

## Test plan

- Frame content: DEPTH=16, FRAME_LEN=4, UART model raises busy 1 cycle after tx_start and holds it 20 cycles. Push samples 0001, 0002, 0003, 0004 → words A55A, 0001, 0002, 0003, 0004, 000A. Exactly 6 tx_start pulses; frame_active is low afterwards; fifo_count=0.
- Checksum wrap: push FFFF, FFFF, 0002, 0000 → checksum word 0000.
- Overflow: tx_busy held at 1, push 20 samples → fifo_count=16, drop_count=4, overflow=1, tx_start never asserted. Continue to 300 drops → drop_count=255.
- Simultaneous push/pop: with 8 samples buffered, assert sample_valid in the same cycle as a DONE-state pop → fifo_count unchanged. Sample order is preserved across pointer wrap; verify over 5 consecutive frames against a reference queue.
- Partial frame: push 3 samples with FRAME_LEN=4 → no tx_start. Push a 4th → header tx_start exactly 2 cycles after that push.
- Reset mid-frame: assert rst during the second sample's ACK → next cycle all outputs at reset values and FIFO empty. A new frame starts correctly after 4 fresh pushes.

Source files
------------

// File: rtl/sample_packetizer_if.sv
// Sample-in / UART-word-out bundle of the sample packetizer.
// The master view belongs to the packetizer; the slave view belongs to its environment.
interface sample_packetizer_if #(
   parameter int DEPTH = 16
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic          sample_valid;
   logic [15:0]   sample_data;
   logic          tx_busy;
   logic          tx_start;
   logic [15:0]   tx_data;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic [7:0]    drop_count;
   logic          frame_active;

   modport master (
      input  sample_valid, sample_data, tx_busy,
      output tx_start, tx_data, fifo_count, overflow, drop_count, frame_active
   );

   modport slave (
      output sample_valid, sample_data, tx_busy,
      input  tx_start, tx_data, fifo_count, overflow, drop_count, frame_active
   );
endinterface

// File: rtl/sample_packetizer.sv
// Buffers ADC samples in a FIFO and frames them as header, FRAME_LEN samples and a
// 16-bit checksum, one word per tx_start/tx_busy handshake with the UART.
module sample_packetizer #(
   parameter int          DEPTH     = 16,
   parameter int          FRAME_LEN = 8,
   parameter logic [15:0] HEADER    = 16'hA55A
) (
   input  logic                 clk,
   input  logic                 rst,
   sample_packetizer_if.master  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(FRAME_LEN + 1);

   typedef enum logic [1:0] {IDLE, SEND, ACK, DONE} state_t;
   typedef enum logic [1:0] {W_HDR, W_SMP, W_SUM} word_t;

   logic [15:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          overflow_r;
   logic [7:0]    drop_r;

   state_t        state_r;
   word_t         kind_r;
   logic [IW-1:0] idx_r;
   logic [15:0]   sum_r;
   logic          tx_start_r;
   logic [15:0]   tx_data_r;
   logic          frame_active_r;

   logic          push_s;
   logic          pop_s;
   logic [15:0]   head_s;

   // Push/pop qualification; a same-cycle pop never frees room for the push
   always_comb begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      head_s = mem_r[rd_ptr_r];
      if (bus.sample_valid && (count_r < CW'(DEPTH))) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
      if ((state_r == DONE) && !bus.tx_busy &&
          ((kind_r == W_HDR) || ((kind_r == W_SMP) && (idx_r < IW'(FRAME_LEN))))) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Sample storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.sample_data;
      end
   end

   // FIFO pointers, occupancy and drop accounting
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
         drop_r     <= 8'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (bus.sample_valid && !push_s) begin
            overflow_r <= 1'b1;
            if (drop_r != 8'hFF) begin
               drop_r <= drop_r + 8'd1;
            end
         end
      end
   end

   // Framing FSM; tx_start is only ever raised on the transition into SEND
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         kind_r         <= W_HDR;
         idx_r          <= '0;
         sum_r          <= 16'h0000;
         tx_start_r     <= 1'b0;
         tx_data_r      <= 16'h0000;
         frame_active_r <= 1'b0;
      end else begin
         tx_start_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if ((count_r >= CW'(FRAME_LEN)) && !bus.tx_busy) begin
                  tx_data_r      <= HEADER;
                  sum_r          <= 16'h0000;
                  idx_r          <= '0;
                  kind_r         <= W_HDR;
                  frame_active_r <= 1'b1;
                  tx_start_r     <= 1'b1;
                  state_r        <= SEND;
               end
            end
            SEND: begin
               state_r <= ACK;
            end
            ACK: begin
               if (bus.tx_busy) begin
                  state_r <= DONE;
               end
            end
            DONE: begin
               if (!bus.tx_busy) begin
                  if (pop_s) begin
                     tx_data_r  <= head_s;
                     sum_r      <= sum_r + head_s;
                     idx_r      <= idx_r + IW'(1);
                     kind_r     <= W_SMP;
                     tx_start_r <= 1'b1;
                     state_r    <= SEND;
                  end else if (kind_r == W_SMP) begin
                     tx_data_r  <= sum_r;
                     kind_r     <= W_SUM;
                     tx_start_r <= 1'b1;
                     state_r    <= SEND;
                  end else begin
                     frame_active_r <= 1'b0;
                     state_r        <= IDLE;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx_start     = tx_start_r;
   assign bus.tx_data      = tx_data_r;
   assign bus.fifo_count   = count_r;
   assign bus.overflow     = overflow_r;
   assign bus.drop_count   = drop_r;
   assign bus.frame_active = frame_active_r;
endmodule

// File: tb/tb_sample_packetizer.sv
// Scoreboard bench for sample_packetizer: stimulus queues expected UART words,
// a monitor pops and compares them on every tx_start.
module tb_sample_packetizer;
   localparam int          DEPTH     = 16;
   localparam int          FRAME_LEN = 4;
   localparam logic [15:0] HEADER    = 16'hA55A;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sample_packetizer_if #(.DEPTH(DEPTH)) bus ();

   sample_packetizer #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .HEADER(HEADER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // UART model: busy from the cycle after tx_start for 20 cycles, unaffected by rst
   logic uart_busy = 1'b0;
   logic hold_busy = 1'b0;
   int   uart_cnt  = 0;
   assign bus.tx_busy = uart_busy | hold_busy;

   always @(posedge clk) begin
      if (bus.tx_start) begin
         uart_busy <= 1'b1;
         uart_cnt  <= 19;
      end else if (uart_cnt > 0) begin
         uart_cnt <= uart_cnt - 1;
      end else begin
         uart_busy <= 1'b0;
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q[$];
   logic [15:0] ref_q[$];
   int          pulses     = 0;
   logic        prev_start = 1'b0;
   logic [15:0] held_word  = 16'h0000;
   logic [15:0] last_word  = 16'h0000;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Reference framing: every FRAME_LEN accepted samples become one frame
   function automatic void model_accept(logic [15:0] d);
      logic [15:0] sum;
      logic [15:0] w;
      ref_q.push_back(d);
      if (ref_q.size() == FRAME_LEN) begin
         sum = 16'h0000;
         exp_q.push_back(HEADER);
         for (int i = 0; i < FRAME_LEN; i++) begin
            w = ref_q.pop_front();
            exp_q.push_back(w);
            sum = sum + w;
         end
         exp_q.push_back(sum);
      end
   endfunction

   task automatic push_sample(input logic [15:0] d, input bit accept);
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample_data  = d;
      if (accept) model_accept(d);
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 4000 && !ok; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.frame_active && !bus.tx_busy) ok = 1'b1;
      end
      check("wait_idle", 32'(ok), 32'd1);
   endtask

   // Monitor: word order, tx_start spacing and tx_data stability during a word
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_start) begin
            pulses++;
            check("tx_start_back_to_back", 32'(prev_start), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_tx_start", 32'd1, 32'd0);
            end else begin
               check("tx_data_word", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
            held_word = bus.tx_data;
            last_word = bus.tx_data;
         end else if (bus.frame_active) begin
            check("tx_data_hold", 32'(bus.tx_data), 32'(held_word));
         end
         prev_start = bus.tx_start;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  base;
      int  seen;
      bit  found;
      bus.sample_valid = 1'b0;
      bus.sample_data  = 16'h0000;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx_start",     32'(bus.tx_start),     32'd0);
      check("rst_tx_data",      32'(bus.tx_data),      32'h0000);
      check("rst_fifo_count",   32'(bus.fifo_count),   32'd0);
      check("rst_overflow",     32'(bus.overflow),     32'd0);
      check("rst_drop_count",   32'(bus.drop_count),   32'd0);
      check("rst_frame_active", 32'(bus.frame_active), 32'd0);
      rst = 1'b0;

      // Frame content: A55A 0001 0002 0003 0004 000A
      base = pulses;
      for (int i = 1; i <= 4; i++) push_sample(16'(i), 1'b1);
      wait_idle();
      check("frame_pulses",       32'(pulses - base),    32'd6);
      check("frame_checksum",     32'(last_word),        32'h000A);
      check("frame_active_after", 32'(bus.frame_active), 32'd0);
      check("frame_fifo_empty",   32'(bus.fifo_count),   32'd0);

      // Checksum wraps modulo 2^16
      push_sample(16'hFFFF, 1'b1);
      push_sample(16'hFFFF, 1'b1);
      push_sample(16'h0002, 1'b1);
      push_sample(16'h0000, 1'b1);
      wait_idle();
      check("checksum_wrap", 32'(last_word), 32'h0000);

      // Partial frame, then header exactly 2 cycles after the completing push
      base = pulses;
      for (int i = 0; i < 3; i++) push_sample(16'h0100 + 16'(i), 1'b1);
      repeat (10) @(negedge clk);
      check("partial_no_start", 32'(pulses - base),  32'd0);
      check("partial_count",    32'(bus.fifo_count), 32'd3);
      push_sample(16'h0103, 1'b1);
      check("partial_t1_start", 32'(bus.tx_start),   32'd0);
      check("partial_t1_count", 32'(bus.fifo_count), 32'd4);
      @(negedge clk);
      check("partial_t2_start", 32'(bus.tx_start),   32'd1);
      wait_idle();

      // Overflow with the UART held busy
      hold_busy = 1'b1;
      base = pulses;
      for (int i = 0; i < 20; i++) push_sample(16'h0200 + 16'(i), i < DEPTH);
      check("ovf_count",    32'(bus.fifo_count), 32'd16);
      check("ovf_drops",    32'(bus.drop_count), 32'd4);
      check("ovf_sticky",   32'(bus.overflow),   32'd1);
      check("ovf_no_start", 32'(pulses - base),  32'd0);
      for (int i = 0; i < 296; i++) push_sample(16'hDEAD, 1'b0);
      check("ovf_drop_sat", 32'(bus.drop_count), 32'd255);
      check("ovf_count2",   32'(bus.fifo_count), 32'd16);
      hold_busy = 1'b0;
      wait_idle();
      check("ovf_drained", 32'(bus.fifo_count), 32'd0);

      // Push in the same cycle as the pop after the header; 5 frames across wrap
      hold_busy = 1'b1;
      for (int i = 0; i < 8; i++) push_sample(16'h0300 + 16'(i), 1'b1);
      check("sim_pre_count", 32'(bus.fifo_count), 32'd8);
      hold_busy = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bus.frame_active && !bus.tx_busy && !bus.tx_start) found = 1'b1;
      end
      check("sim_pop_found", 32'(found), 32'd1);
      bus.sample_valid = 1'b1;
      bus.sample_data  = 16'h0308;
      model_accept(16'h0308);
      @(negedge clk);
      bus.sample_valid = 1'b0;
      check("sim_push_pop_count", 32'(bus.fifo_count), 32'd8);
      wait_idle();
      for (int i = 9; i < 20; i++) push_sample(16'h0300 + 16'(i), 1'b1);
      wait_idle();
      check("wrap_fifo_empty", 32'(bus.fifo_count), 32'd0);

      // Reset during the second sample's ACK
      for (int i = 0; i < 4; i++) push_sample(16'h0400 + 16'(i), 1'b1);
      seen = 0;
      for (int i = 0; i < 400 && seen < 3; i++) begin
         @(negedge clk);
         if (bus.tx_start) seen++;
      end
      check("rst_mid_reached", 32'(seen), 32'd3);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      ref_q.delete();
      @(negedge clk);
      check("midrst_tx_start",     32'(bus.tx_start),     32'd0);
      check("midrst_tx_data",      32'(bus.tx_data),      32'h0000);
      check("midrst_fifo_count",   32'(bus.fifo_count),   32'd0);
      check("midrst_overflow",     32'(bus.overflow),     32'd0);
      check("midrst_drop_count",   32'(bus.drop_count),   32'd0);
      check("midrst_frame_active", 32'(bus.frame_active), 32'd0);
      rst = 1'b0;
      base = pulses;
      push_sample(16'h1111, 1'b1);
      push_sample(16'h2222, 1'b1);
      push_sample(16'h3333, 1'b1);
      push_sample(16'h4444, 1'b1);
      wait_idle();
      check("post_rst_pulses",   32'(pulses - base), 32'd6);
      check("post_rst_checksum", 32'(last_word),     32'hAAAA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
